sram_port_arbiter: RTL and testbench

//  Shares one single-port SRAM macro (1-cycle read latency) between two requesters.
//  M0 is the instruction-fetch side and M1 is the data load/store side.
//  The block does per-cycle arbitration, supports optional locked bursts, and steers read data back.
//  It sits between the bus-to-SRAM bridges and the SRAM instance when ITCM and DTCM merge into one bank.

---
 rtl/sram_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_sram_port_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Shares one single-port SRAM (1-cycle read latency) between an instruction-fetch
// master (M0) and a data load/store master (M1). Arbitration is per cycle with
// optional locked bursts bounded by MAX_LOCK. Read data is broadcast to both
// masters, and a one-cycle-delayed rvalid marks the master that owns it.
// Build option: define SRAM_ARB_RR_EN for round-robin on conflicts. Left
// undefined, M1 has fixed priority over M0.
module sram_port_arbiter #(
    parameter int AW       = 14,
    parameter int DW       = 32,
    parameter int MAX_LOCK = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            m0_req,
    input  logic            m0_we,
    input  logic [DW/8-1:0] m0_be,
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW-1:0]   m0_wdata,
    input  logic            m0_lock,
    output logic            m0_gnt,
    output logic            m0_rvalid,
    output logic [DW-1:0]   m0_rdata,
    input  logic            m1_req,
    input  logic            m1_we,
    input  logic [DW/8-1:0] m1_be,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW-1:0]   m1_wdata,
    input  logic            m1_lock,
    output logic            m1_gnt,
    output logic            m1_rvalid,
    output logic [DW-1:0]   m1_rdata,
    output logic            sram_cs,
    output logic [AW-1:0]   sram_addr,
    output logic [DW/8-1:0] sram_wen,
    output logic [DW-1:0]   sram_wdata,
    input  logic [DW-1:0]   sram_rdata
);

    localparam int BW = DW / 8;
    localparam int CW = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] LOCK_MAX_C = CW'(MAX_LOCK);
    localparam logic [CW-1:0] LOCK_ONE_C = CW'(1);
    localparam logic [CW-1:0] LOCK_ZERO_C = CW'(0);
    localparam logic M0_C = 1'b0;
    localparam logic M1_C = 1'b1;

    // Master that won the most recent grant (lock tracking, round-robin pointer)
    logic          last_gnt_r;
    // Consecutive locked grants to last_gnt_r; zero means no lock is held
    logic [CW-1:0] lock_cnt_r;
    logic [CW-1:0] lock_cnt_nxt_s;
    // One-hot owner of the read issued last cycle: bit0 = M0, bit1 = M1
    logic [1:0]    rd_owner_r;

    logic          holder_req_s;
    logic          other_req_s;
    logic          win_valid_s;
    logic          win_s;
    logic          win_we_s;
    logic          win_lock_s;
    logic [BW-1:0] win_be_s;

    assign holder_req_s = (last_gnt_r == M1_C) ? m1_req : m0_req;
    assign other_req_s  = (last_gnt_r == M1_C) ? m0_req : m1_req;

    // Pick this cycle's winner: lock hold first, then conflict policy, then lone requester
    always_comb begin
        win_valid_s = 1'b0;
        win_s       = M0_C;
        if (rst) begin
            win_valid_s = 1'b0;
        end else if ((lock_cnt_r != LOCK_ZERO_C) && holder_req_s) begin
            // Previous winner locked and still asking; the limit only bites if the other side waits
            win_valid_s = 1'b1;
            if ((lock_cnt_r < LOCK_MAX_C) || !other_req_s) begin
                win_s = last_gnt_r;
            end else begin
                win_s = ~last_gnt_r;
            end
        end else if (m0_req && m1_req) begin
            win_valid_s = 1'b1;
`ifdef SRAM_ARB_RR_EN
            win_s = ~last_gnt_r;
`else
            win_s = M1_C;
`endif
        end else if (m1_req) begin
            win_valid_s = 1'b1;
            win_s       = M1_C;
        end else if (m0_req) begin
            win_valid_s = 1'b1;
            win_s       = M0_C;
        end else begin
            win_valid_s = 1'b0;
            win_s       = M0_C;
        end
    end

    assign m0_gnt     = win_valid_s && (win_s == M0_C);
    assign m1_gnt     = win_valid_s && (win_s == M1_C);
    assign win_we_s   = (win_s == M1_C) ? m1_we   : m0_we;
    assign win_lock_s = (win_s == M1_C) ? m1_lock : m0_lock;
    assign win_be_s   = (win_s == M1_C) ? m1_be   : m0_be;

    // SRAM side follows the winner; address and data default to M0 when idle
    assign sram_cs    = win_valid_s;
    assign sram_addr  = m1_gnt ? m1_addr  : m0_addr;
    assign sram_wdata = m1_gnt ? m1_wdata : m0_wdata;
    assign sram_wen   = (win_valid_s && win_we_s) ? win_be_s : {BW{1'b0}};

    // Next lock count: first locked grant counts 1, repeats to the same master saturate at MAX_LOCK
    always_comb begin
        lock_cnt_nxt_s = LOCK_ZERO_C;
        if (win_valid_s && win_lock_s) begin
            if ((win_s == last_gnt_r) && (lock_cnt_r != LOCK_ZERO_C)) begin
                if (lock_cnt_r < LOCK_MAX_C) begin
                    lock_cnt_nxt_s = lock_cnt_r + LOCK_ONE_C;
                end else begin
                    lock_cnt_nxt_s = lock_cnt_r;
                end
            end else begin
                lock_cnt_nxt_s = LOCK_ONE_C;
            end
        end else begin
            lock_cnt_nxt_s = LOCK_ZERO_C;
        end
    end

    // Arbitration state and read-owner tracking; reset drops any pending read return
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_r <= M1_C;
            lock_cnt_r <= LOCK_ZERO_C;
            rd_owner_r <= 2'b00;
        end else begin
            if (win_valid_s) begin
                last_gnt_r <= win_s;
            end else begin
                last_gnt_r <= last_gnt_r;
            end
            lock_cnt_r <= lock_cnt_nxt_s;
            rd_owner_r <= {m1_gnt & ~m1_we, m0_gnt & ~m0_we};
        end
    end

    assign m0_rvalid = rd_owner_r[0];
    assign m1_rvalid = rd_owner_r[1];
    assign m0_rdata  = sram_rdata;
    assign m1_rdata  = sram_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural 1-cycle-latency SRAM.
// Inputs change on the falling edge and outputs are checked 1 ns later.
module tb_sram_port_arbiter;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
    logic [BW-1:0] m0_be, m1_be;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          sram_cs;
    logic [AW-1:0] sram_addr;
    logic [BW-1:0] sram_wen;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata = 32'h0000_0000;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_lock(m0_lock), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_lock(m1_lock), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .sram_cs(sram_cs), .sram_addr(sram_addr), .sram_wen(sram_wen),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    // Behavioural SRAM: byte-enabled write, read data one cycle after the read
    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_wen == 4'b0000) begin
                sram_rdata <= mem[sram_addr];
            end else begin
                for (int b = 0; b < BW; b++) begin
                    if (sram_wen[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
                end
            end
        end
    end

    task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drv0(input logic req, input logic we, input logic lock,
                        input logic [AW-1:0] addr, input logic [BW-1:0] be, input logic [DW-1:0] wd);
        m0_req = req; m0_we = we; m0_lock = lock; m0_addr = addr; m0_be = be; m0_wdata = wd;
    endtask

    task automatic drv1(input logic req, input logic we, input logic lock,
                        input logic [AW-1:0] addr, input logic [BW-1:0] be, input logic [DW-1:0] wd);
        m1_req = req; m1_we = we; m1_lock = lock; m1_addr = addr; m1_be = be; m1_wdata = wd;
    endtask

    initial begin
        logic exp_w;
        logic prev_v;
        logic prev_w;

        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0000_0000;
        mem[14'h010] = 32'hA5A5_0001;
        mem[14'h020] = 32'hFFFF_FFFF;
        mem[14'h100] = 32'h0000_0100;
        mem[14'h200] = 32'h0000_0200;

        // Reset with both masters requesting: nothing may be granted
        rst = 1'b1;
        drv0(1'b1, 1'b0, 1'b0, 14'h100, 4'h0, 32'h0);
        drv1(1'b1, 1'b0, 1'b0, 14'h200, 4'h0, 32'h0);
        @(negedge clk); #1;
        ck("rst_m0_gnt", {31'd0, m0_gnt}, 32'd0);
        ck("rst_m1_gnt", {31'd0, m1_gnt}, 32'd0);
        ck("rst_cs", {31'd0, sram_cs}, 32'd0);
        ck("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);

        // 1: lone M0 read of 0x010
        @(negedge clk);
        rst = 1'b0;
        drv0(1'b1, 1'b0, 1'b0, 14'h010, 4'h0, 32'h0);
        drv1(1'b0, 1'b0, 1'b0, 14'h000, 4'h0, 32'h0);
        #1;
        ck("t1_m0_gnt", {31'd0, m0_gnt}, 32'd1);
        ck("t1_m1_gnt", {31'd0, m1_gnt}, 32'd0);
        ck("t1_cs", {31'd0, sram_cs}, 32'd1);
        ck("t1_wen", {28'd0, sram_wen}, 32'd0);
        ck("t1_addr", {18'd0, sram_addr}, 32'h010);
        @(negedge clk);
        drv0(1'b0, 1'b0, 1'b0, 14'h000, 4'h0, 32'h0);
        #1;
        ck("t1_m0_rvalid", {31'd0, m0_rvalid}, 32'd1);
        ck("t1_m0_rdata", m0_rdata, 32'hA5A5_0001);
        ck("t1_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
        ck("t1_idle_cs", {31'd0, sram_cs}, 32'd0);

        // 2: M1 partial write then read back the merged word
        @(negedge clk);
        drv1(1'b1, 1'b1, 1'b0, 14'h020, 4'b0011, 32'h1234_5678);
        #1;
        ck("t2_wr_gnt", {31'd0, m1_gnt}, 32'd1);
        ck("t2_wr_wen", {28'd0, sram_wen}, 32'h3);
        ck("t2_wr_wdata", sram_wdata, 32'h1234_5678);
        ck("t2_wr_addr", {18'd0, sram_addr}, 32'h020);
        @(negedge clk);
        drv1(1'b1, 1'b0, 1'b0, 14'h020, 4'b0000, 32'h0);
        #1;
        ck("t2_wr_no_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        ck("t2_rd_gnt", {31'd0, m1_gnt}, 32'd1);
        ck("t2_rd_wen", {28'd0, sram_wen}, 32'd0);
        @(negedge clk);
        drv1(1'b0, 1'b0, 1'b0, 14'h000, 4'h0, 32'h0);
        #1;
        ck("t2_m1_rvalid", {31'd0, m1_rvalid}, 32'd1);
        ck("t2_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
        ck("t2_rdata", m1_rdata, 32'hFFFF_5678);

        // 3: both masters read every cycle, no lock (last grant was M1)
        prev_v = 1'b0; prev_w = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drv0(1'b1, 1'b0, 1'b0, 14'h100, 4'h0, 32'h0);
            drv1(1'b1, 1'b0, 1'b0, 14'h200, 4'h0, 32'h0);
            #1;
`ifdef SRAM_ARB_RR_EN
            exp_w = (i % 2 == 1);
`else
            exp_w = 1'b1;
`endif
            ck("t3_m1_gnt", {31'd0, m1_gnt}, {31'd0, exp_w});
            ck("t3_m0_gnt", {31'd0, m0_gnt}, {31'd0, ~exp_w});
            ck("t3_rvalid", {30'd0, m1_rvalid, m0_rvalid},
               prev_v ? (prev_w ? 32'd2 : 32'd1) : 32'd0);
            if (prev_v) ck("t3_rdata", m1_rdata, prev_w ? 32'h0000_0200 : 32'h0000_0100);
            prev_v = 1'b1; prev_w = exp_w;
        end
        @(negedge clk);
        drv0(1'b0, 1'b0, 1'b0, 14'h000, 4'h0, 32'h0);
        drv1(1'b0, 1'b0, 1'b0, 14'h000, 4'h0, 32'h0);
        #1;
        ck("t3_last_rvalid", {30'd0, m1_rvalid, m0_rvalid}, prev_w ? 32'd2 : 32'd1);

        // 4: M0 locked reads, M1 joins from the second cycle
        prev_v = 1'b0; prev_w = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drv0(1'b1, 1'b0, 1'b1, 14'h100, 4'h0, 32'h0);
            drv1((i > 0), 1'b0, 1'b0, 14'h200, 4'h0, 32'h0);
            #1;
`ifdef SRAM_ARB_RR_EN
            exp_w = (i % 5 == 4);
`else
            exp_w = (i >= 4);
`endif
            ck("t4_m0_gnt", {31'd0, m0_gnt}, {31'd0, ~exp_w});
            ck("t4_m1_gnt", {31'd0, m1_gnt}, {31'd0, exp_w});
            ck("t4_rvalid", {30'd0, m1_rvalid, m0_rvalid},
               prev_v ? (prev_w ? 32'd2 : 32'd1) : 32'd0);
            prev_v = 1'b1; prev_w = exp_w;
        end

        // 5: reset while a read is outstanding and both masters request
        @(negedge clk);
        drv0(1'b1, 1'b0, 1'b0, 14'h100, 4'h0, 32'h0);
        drv1(1'b1, 1'b0, 1'b0, 14'h200, 4'h0, 32'h0);
        #1;
        @(negedge clk); #1;
        ck("t5_pending", {31'd0, m0_rvalid | m1_rvalid}, 32'd1);
        rst = 1'b1;
        #1;
        ck("t5_rvalid_drop", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        ck("t5_gnt_rst", {30'd0, m1_gnt, m0_gnt}, 32'd0);
        ck("t5_cs_rst", {31'd0, sram_cs}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        ck("t5_no_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
`ifdef SRAM_ARB_RR_EN
        ck("t5_restart_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
`else
        ck("t5_restart_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd2);
`endif

        // 6: lone M1 with lock for 10 cycles, then M0 asks at the saturated limit
        @(negedge clk);
        drv0(1'b0, 1'b0, 1'b0, 14'h000, 4'h0, 32'h0);
        drv1(1'b0, 1'b0, 1'b0, 14'h000, 4'h0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drv1(1'b1, 1'b0, 1'b1, 14'h200, 4'h0, 32'h0);
            #1;
            ck("t6_m1_gnt", {31'd0, m1_gnt}, 32'd1);
            ck("t6_cs", {31'd0, sram_cs}, 32'd1);
            if (i > 0) ck("t6_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd2);
        end
        @(negedge clk);
        drv0(1'b1, 1'b0, 1'b0, 14'h100, 4'h0, 32'h0);
        #1;
        ck("t6_limit_m0_gnt", {31'd0, m0_gnt}, 32'd1);
        ck("t6_limit_m1_gnt", {31'd0, m1_gnt}, 32'd0);
        @(negedge clk);
        drv0(1'b0, 1'b0, 1'b0, 14'h000, 4'h0, 32'h0);
        drv1(1'b0, 1'b0, 1'b0, 14'h000, 4'h0, 32'h0);
        #1;
        ck("t6_limit_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd1);
        ck("t6_limit_rdata", m0_rdata, 32'h0000_0100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
